// File: rtl/filter_stream_arbiter.sv
// rtl/filter_stream_arbiter.sv - packet-granular round-robin arbiter feeding the filter datapath
// Two AXIS sources share one filter input; per-packet grants, guard gaps and a length watchdog.
module filter_stream_arbiter #(
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_PKT_LEN = 4096
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] s0_axis_tdata_i,
  input  logic              s0_axis_tvalid_i,
  input  logic              s0_axis_tlast_i,
  output logic              s0_axis_tready_o,
  input  logic [DATA_W-1:0] s1_axis_tdata_i,
  input  logic              s1_axis_tvalid_i,
  input  logic              s1_axis_tlast_i,
  output logic              s1_axis_tready_o,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  output logic              m_axis_tlast_o,
  output logic              grant_o,
  output logic              busy_o,
  output logic              trunc_o
);

  localparam int BEAT_W   = $clog2(MAX_PKT_LEN + 1);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN, GAP} state_e;

  state_e              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic [BEAT_W-1:0]   beat_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [DATA_W-1:0]   m_tdata_q;
  logic                m_tvalid_q;
  logic                m_tlast_q;
  logic                trunc_q;

  logic                owner_ready;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic                accept;

  // Readies come straight from registered state so the sources never see a combinational path.
  assign s0_axis_tready_o = (state_q == GRANT0) || (state_q == DRAIN && !grant_q);
  assign s1_axis_tready_o = (state_q == GRANT1) || (state_q == DRAIN &&  grant_q);

  assign owner_ready = grant_q ? s1_axis_tready_o : s0_axis_tready_o;
  assign sel_valid   = grant_q ? s1_axis_tvalid_i : s0_axis_tvalid_i;
  assign sel_last    = grant_q ? s1_axis_tlast_i  : s0_axis_tlast_i;
  assign sel_data    = grant_q ? s1_axis_tdata_i  : s0_axis_tdata_i;
  assign accept      = sel_valid && owner_ready;
  assign beat_cnt_d  = beat_cnt_q + 1'b1;

  assign m_axis_tdata_o  = m_tdata_q;
  assign m_axis_tvalid_o = m_tvalid_q;
  assign m_axis_tlast_o  = m_tlast_q;
  assign trunc_o         = trunc_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      trunc_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s0_axis_tvalid_i && (!s1_axis_tvalid_i || last_grant_q)) begin
            state_q      <= GRANT0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            beat_cnt_q   <= '0;
          end else if (s1_axis_tvalid_i) begin
            state_q      <= GRANT1;
            grant_q      <= 1'b1;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= sel_data;
            beat_cnt_q <= beat_cnt_d;
            if (sel_last) begin
              m_tlast_q <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end else if (beat_cnt_d == BEAT_W'(MAX_PKT_LEN)) begin
              // Runaway packet: close it towards the filter, swallow the rest.
              m_tlast_q <= 1'b1;
              trunc_q   <= 1'b1;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept && sel_last) begin
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
